// File: rtl/fp_rsqrt_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_rsqrt_pkg : shared constants and result classes for the 1/sqrt pack   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package fp_rsqrt_pkg;

   localparam int BIAS    = 127;
   localparam int SQRT2_W = 26;
   // sqrt(2) truncated to 1.25 fixed point
   localparam logic [SQRT2_W-1:0] SQRT2 = 26'h2D413CC;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      CLS_NORM = 3'd0,
      CLS_NAN  = 3'd1,
      CLS_NEG  = 3'd2,
      CLS_ZERO = 3'd3,
      CLS_INF  = 3'd4
   } cls_e;

endpackage
`default_nettype wire

// File: rtl/fp_rsqrt_pack_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_rsqrt_pack_if : operand/side-band input and IEEE result output bus    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface fp_rsqrt_pack_if #(
   parameter int WL  = 24,
   parameter int EWL = 8
);
   logic           in_valid;
   logic [WL-1:0]  mant_in;
   logic           sign_in;
   logic [EWL-1:0] exp_in;
   logic           frac_nz_in;
   logic           out_valid;
   logic [31:0]    dout;
   logic           flag_invalid;
   logic           flag_divzero;

   modport master (
      output in_valid, mant_in, sign_in, exp_in, frac_nz_in,
      input  out_valid, dout, flag_invalid, flag_divzero
   );

   modport slave (
      input  in_valid, mant_in, sign_in, exp_in, frac_nz_in,
      output out_valid, dout, flag_invalid, flag_divzero
   );
endinterface
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_round_rne : round a 1.x significand to FRAC_W bits, nearest-even      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module fp_round_rne #(
   parameter int SIG_W  = 49,
   parameter int FRAC_W = 23
) (
   input  logic [SIG_W-1:0]  sig,
   output logic [FRAC_W-1:0] frac,
   output logic              carry
);
   localparam int G = SIG_W - 2 - FRAC_W;

   logic            up;
   logic [FRAC_W:0] sum;

   always_comb begin
      up    = sig[G] & (sig[G-1] | (|sig[G-2:0]) | sig[G+1]);
      sum   = {1'b0, sig[SIG_W-2 -: FRAC_W]} + (FRAC_W+1)'(up);
      frac  = sum[FRAC_W-1:0];
      // fraction wrap only means 2.0 when the integer bit was already set
      carry = sum[FRAC_W] & sig[SIG_W-1];
   end
endmodule
`default_nettype wire

// File: rtl/fp_rsqrt_pack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_rsqrt_pack : 2-stage exponent/sqrt2/round/pack of 1/sqrt mantissa     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module fp_rsqrt_pack #(
   parameter int WL   = 24,
   parameter int KWL  = 26,
   parameter int EWL  = 8,
   parameter int BIAS = 127
) (
   input logic            CLK,
   input logic            RST,
   input logic            CE,
   fp_rsqrt_pack_if.slave bus
);
   import fp_rsqrt_pkg::*;

   localparam int PW     = WL + KWL;
   localparam int SW     = PW - 1;
   localparam int EW2    = EWL + 2;
   localparam int FRAC_W = 31 - EWL;
   localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
   localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
   localparam logic [KWL-1:0]        C_SQRT2 = KWL'(SQRT2);

   logic                  v1_q, v1_d, sign1_q, sign1_d, odd_q, odd_d;
   cls_e                  cls_q, cls_d;
   logic signed [EW2-1:0] er_q, er_d;
   logic [SW-1:0]         sig_q, sig_d;
   logic                  v2_q, v2_d, inv_q, inv_d, dz_q, dz_d;
   logic [31:0]           dout_q, dout_d;

   logic                  exp_ones, exp_zero;
   logic signed [EW2-1:0] e_w, e_half, er_odd, er_s1;
   logic [PW-1:0]         prod;
   logic [SW-1:0]         sig_s1;
   cls_e                  cls_s1;

   always_comb begin
      exp_ones = &bus.exp_in;
      exp_zero = ~|bus.exp_in;
      e_w      = $signed({2'b00, bus.exp_in}) - BIAS_S;
      e_half   = e_w >>> 1;
      er_odd   = -((e_w + ONE_S) >>> 1);
      prod     = PW'(bus.mant_in) * PW'(C_SQRT2);

      if (exp_ones && bus.frac_nz_in)                      cls_s1 = CLS_NAN;
      else if (bus.sign_in && !(exp_zero && !bus.frac_nz_in)) cls_s1 = CLS_NEG;
      else if (exp_zero)                                   cls_s1 = CLS_ZERO;
      else if (exp_ones)                                   cls_s1 = CLS_INF;
      else                                                 cls_s1 = CLS_NORM;

      if (e_w[0]) begin
         // a product at or above 2.0 cannot occur in range; renormalise anyway
         if (prod[PW-1]) begin
            er_s1  = er_odd + ONE_S;
            sig_s1 = {prod[PW-1:2], |prod[1:0]};
         end else begin
            er_s1  = er_odd;
            sig_s1 = prod[SW-1:0];
         end
      end else if (bus.mant_in[WL-1]) begin
         er_s1  = -e_half;
         sig_s1 = {bus.mant_in, (SW-WL)'(0)};
      end else begin
         er_s1  = -e_half - ONE_S;
         sig_s1 = {bus.mant_in[WL-2:0], (SW-WL+1)'(0)};
      end
   end

   always_comb begin
      v1_d    = v1_q;
      cls_d   = cls_q;
      sign1_d = sign1_q;
      odd_d   = odd_q;
      er_d    = er_q;
      sig_d   = sig_q;
      if (CE) begin
         v1_d    = bus.in_valid;
         cls_d   = cls_s1;
         sign1_d = bus.sign_in;
         odd_d   = e_w[0];
         er_d    = er_s1;
         sig_d   = sig_s1;
      end
   end

   logic [FRAC_W-1:0] rnd_frac, frac2;
   logic              rnd_carry;
   logic [EWL-1:0]    exp2;
   logic [31:0]       res;
   logic              res_inv, res_dz;

   fp_round_rne #(.SIG_W(SW), .FRAC_W(FRAC_W)) u_round (
      .sig   (sig_q),
      .frac  (rnd_frac),
      .carry (rnd_carry)
   );

   always_comb begin
      // even-exponent significands are exact, so rounding applies only when odd
      frac2   = odd_q ? rnd_frac : sig_q[SW-2 -: FRAC_W];
      exp2    = EWL'(er_q + BIAS_S + ((odd_q && rnd_carry) ? ONE_S : '0));
      res     = {1'b0, exp2, frac2};
      res_inv = 1'b0;
      res_dz  = 1'b0;
      case (cls_q)
         CLS_NAN, CLS_NEG: begin
            res     = QNAN;
            res_inv = 1'b1;
         end
         CLS_ZERO: begin
            res    = {sign1_q, PINF[30:0]};
            res_dz = 1'b1;
         end
         CLS_INF: res = 32'h0;
         default: ;
      endcase

      v2_d   = v2_q;
      dout_d = dout_q;
      inv_d  = inv_q;
      dz_d   = dz_q;
      if (CE) begin
         v2_d = v1_q;
         if (v1_q) begin
            dout_d = res;
            inv_d  = res_inv;
            dz_d   = res_dz;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         v1_q    <= 1'b0;
         cls_q   <= CLS_NORM;
         sign1_q <= 1'b0;
         odd_q   <= 1'b0;
         er_q    <= '0;
         sig_q   <= '0;
         v2_q    <= 1'b0;
         dout_q  <= '0;
         inv_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         cls_q   <= cls_d;
         sign1_q <= sign1_d;
         odd_q   <= odd_d;
         er_q    <= er_d;
         sig_q   <= sig_d;
         v2_q    <= v2_d;
         dout_q  <= dout_d;
         inv_q   <= inv_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.out_valid    = v2_q;
   assign bus.dout         = dout_q;
   assign bus.flag_invalid = inv_q;
   assign bus.flag_divzero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_rsqrt_pack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fp_rsqrt_pack : directed scoreboard bench for fp_rsqrt_pack           |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_fp_rsqrt_pack;

   typedef struct packed {
      logic [31:0] d;
      logic        inv;
      logic        dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   fp_rsqrt_pack_if #(.WL(24), .EWL(8)) bus ();

   fp_rsqrt_pack #(.WL(24), .KWL(26), .EWL(8), .BIAS(127)) dut (
      .CLK (clk),
      .RST (rst),
      .CE  (ce),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // independent reference for normal operands
   function automatic logic [31:0] model_norm(input logic [23:0] m, input logic [7:0] e);
      int          ee, er;
      logic [63:0] p;
      logic [23:0] f;
      ee = int'(e) - 127;
      if ((ee & 1) == 0) begin
         if (m[23]) begin er = -ee / 2;     f = {1'b0, m[22:0]};       end
         else       begin er = -ee / 2 - 1; f = {1'b0, m[21:0], 1'b0}; end
      end else begin
         p  = 64'(m) * 64'h2D413CC;
         er = -(ee + 1) / 2;
         f  = {1'b0, p[47:25]};
         if (p[24] && (p[25] || (|p[23:0]))) f = f + 24'd1;
         if (f[23]) begin f = '0; er = er + 1; end
      end
      return {1'b0, 8'(er + 127), f[22:0]};
   endfunction

   task automatic tick();
      logic        ce_s, rst_s, v_p, i_p, z_p;
      logic [31:0] d_p;
      exp_t        e;
      ce_s = ce; rst_s = rst;
      v_p = bus.out_valid; d_p = bus.dout; i_p = bus.flag_invalid; z_p = bus.flag_divzero;
      @(posedge clk);
      #1;
      if (rst_s) begin
         chk("rst_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_dout", bus.dout, 32'd0);
         chk("rst_inv", 32'(bus.flag_invalid), 32'd0);
         chk("rst_dz", 32'(bus.flag_divzero), 32'd0);
      end else if (!ce_s) begin
         chk("hold_valid", 32'(bus.out_valid), 32'(v_p));
         chk("hold_dout", bus.dout, d_p);
         chk("hold_flags", {30'd0, bus.flag_invalid, bus.flag_divzero}, {30'd0, i_p, z_p});
      end else if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 32'(bus.out_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("dout", bus.dout, e.d);
            chk("flag_invalid", 32'(bus.flag_invalid), 32'(e.inv));
            chk("flag_divzero", 32'(bus.flag_divzero), 32'(e.dz));
         end
      end
   endtask

   task automatic drive(input logic [23:0] m, input logic s, input logic [7:0] e, input logic nz);
      bus.in_valid   = 1'b1;
      bus.mant_in    = m;
      bus.sign_in    = s;
      bus.exp_in     = e;
      bus.frac_nz_in = nz;
   endtask

   task automatic send(input logic [23:0] m, input logic s, input logic [7:0] e, input logic nz,
                       input logic [31:0] d, input logic inv, input logic dz);
      exp_t x;
      drive(m, s, e, nz);
      x.d = d; x.inv = inv; x.dz = dz;
      if (ce) sb.push_back(x);
      tick();
   endtask

   task automatic send_norm(input logic [23:0] m, input logic [7:0] e);
      assert (m[23] | m[22]) else $error("bench drove a non-normalised mantissa %h", m);
      send(m, 1'b0, e, 1'b0, model_norm(m, e), 1'b0, 1'b0);
   endtask

   task automatic idle_drain();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.mant_in = '0; bus.sign_in = 1'b0;
      bus.exp_in = '0; bus.frac_nz_in = 1'b0;

      rst = 1'b1; ce = 1'b0;
      tick(); tick();
      rst = 1'b0; ce = 1'b1;
      bus.in_valid = 1'b0;
      tick();

      // x = 1.0 with explicit latency check
      send(24'h800000, 1'b0, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0);
      chk("lat_early", 32'(bus.out_valid), 32'd0);
      idle_drain();

      // even exponents, odd exponents
      send(24'h800000, 1'b0, 8'd129, 1'b0, 32'h3F000000, 1'b0, 1'b0);
      send(24'h600000, 1'b0, 8'd129, 1'b0, 32'h3EC00000, 1'b0, 1'b0);
      send(24'h800000, 1'b0, 8'd128, 1'b0, 32'h3F3504F3, 1'b0, 1'b0);
      send(24'h800000, 1'b0, 8'd126, 1'b0, 32'h3FB504F3, 1'b0, 1'b0);
      // specials
      send(24'h5A0000, 1'b0, 8'd0,   1'b0, 32'h7F800000, 1'b0, 1'b1);
      send(24'h5A0000, 1'b1, 8'd0,   1'b0, 32'hFF800000, 1'b0, 1'b1);
      send(24'h7FFFFF, 1'b0, 8'd0,   1'b1, 32'h7F800000, 1'b0, 1'b1);
      send(24'h800000, 1'b1, 8'd129, 1'b0, 32'h7FC00000, 1'b1, 1'b0);
      send(24'h800000, 1'b0, 8'd255, 1'b0, 32'h00000000, 1'b0, 1'b0);
      send(24'h800000, 1'b0, 8'd255, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
      send(24'h800000, 1'b1, 8'd0,   1'b1, 32'h7FC00000, 1'b1, 1'b0);
      // range ends and random normals against the model
      send_norm(24'h5A827A, 8'd128);
      send_norm(24'h7FFFFF, 8'd126);
      send_norm(24'h7FFFFF, 8'd1);
      send_norm(24'h5A827A, 8'd254);
      for (int i = 0; i < 12; i++)
         send_norm(24'($urandom_range(32'h5A827A, 32'h7FFFFF)), 8'($urandom_range(1, 254)));
      idle_drain();

      // stall after the second of three operands
      send_norm(24'h6A0000, 8'd131);
      send_norm(24'h700001, 8'd100);
      ce = 1'b0;
      drive(24'h7C0000, 1'b0, 8'd60, 1'b0);
      tick(); tick();
      ce = 1'b1;
      send_norm(24'h7C0000, 8'd60);
      idle_drain();

      // reset while operands are in flight and CE is low
      send_norm(24'h650000, 8'd140);
      send_norm(24'h750000, 8'd141);
      ce = 1'b0; rst = 1'b1;
      tick();
      sb.delete();
      rst = 1'b0; ce = 1'b1; bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
